lsu: RTL and testbench

//   Load/store unit for the single-cycle RV32 core. Decodes the data address

---
 rtl/lsu.sv | 159 +++++++++++++++
 tb/tb_lsu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit for the single-cycle RV32 core.
// Decodes the data address into on-chip data memory, the LED / 7-seg / LCD
// output registers and the switch input, performs byte/half/word stores with
// lane masking and extends byte/half loads.
// Optional feature macro: LSU_UNSIGNED_EN adds i_lsu_unsigned, which selects
// zero-extension for byte/half loads (sign-extension otherwise).
module lsu #(
  parameter int DMEM_DEPTH = 512
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [1:0]  i_lsu_size,
`ifdef LSU_UNSIGNED_EN
  input  logic        i_lsu_unsigned,
`endif
  input  logic        i_lsu_wren,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex [0:7],
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw
);

  localparam int AW = $clog2(DMEM_DEPTH);  // word index width
  localparam int MW = AW + 2;              // byte address width of DMEM

  typedef enum logic [2:0] {
    R_NONE, R_DMEM, R_LEDR, R_LEDG, R_HEXLO, R_HEXHI, R_LCD, R_SW
  } region_e;

  region_e        region;
  logic [3:0]     be;
  logic [31:0]    wdata;
  logic [31:0]    rword;
  logic [7:0]     bval;
  logic [15:0]    hval;
  logic           uns;
  logic [AW-1:0]  idx;
  logic [31:0]    mem [DMEM_DEPTH];

`ifdef LSU_UNSIGNED_EN
  assign uns = i_lsu_unsigned;
`else
  assign uns = 1'b0;
`endif

  assign idx = i_lsu_addr[MW-1:2];

  // Byte-lane merge shared by all 32-bit peripheral registers.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [3:0]  lanes,
                                        input logic [31:0] nd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (lanes[b]) r[8*b +: 8] = nd[8*b +: 8];
    return r;
  endfunction

  // Full 32-bit address decode; peripherals occupy one 4 KiB page each.
  always_comb begin
    region = R_NONE;
    if (i_lsu_addr[31:MW] == '0) begin
      region = R_DMEM;
    end else begin
      case (i_lsu_addr[31:12])
        20'h10000: region = R_LEDR;
        20'h10001: region = R_LEDG;
        20'h10002: region = R_HEXLO;
        20'h10003: region = R_HEXHI;
        20'h10004: region = R_LCD;
        20'h10010: region = R_SW;
        default:   region = R_NONE;
      endcase
    end
  end

  // Store lane enables; data is replicated so every enabled lane sees the
  // right-aligned store value regardless of offset.
  always_comb begin
    be    = 4'hF;
    wdata = i_st_data;
    case (i_lsu_size)
      2'b00: begin
        be    = 4'b0001 << i_lsu_addr[1:0];
        wdata = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wdata = i_st_data;
      end
    endcase
  end

  // Data memory: byte-masked write, no reset (contents undefined until written).
  always_ff @(posedge i_clk) begin
    if (i_lsu_wren && region == R_DMEM) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Output peripheral registers; reset wins over a concurrent store.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_lcd  <= '0;
      for (int n = 0; n < 8; n++) o_io_hex[n] <= '0;
    end else if (i_lsu_wren) begin
      if (region == R_LEDR) o_io_ledr <= merge(o_io_ledr, be, wdata);
      if (region == R_LEDG) o_io_ledg <= merge(o_io_ledg, be, wdata);
      if (region == R_LCD)  o_io_lcd  <= merge(o_io_lcd,  be, wdata);
      // Each byte lane owns one 7-seg digit; bit 7 of the lane is dropped.
      for (int n = 0; n < 4; n++) begin
        if (region == R_HEXLO && be[n]) o_io_hex[n]   <= wdata[8*n +: 7];
        if (region == R_HEXHI && be[n]) o_io_hex[n+4] <= wdata[8*n +: 7];
      end
    end
  end

  // Combinational read of the selected word (old content during a store).
  always_comb begin
    rword = '0;
    case (region)
      R_DMEM:  rword = mem[idx];
      R_LEDR:  rword = o_io_ledr;
      R_LEDG:  rword = o_io_ledg;
      R_HEXLO: rword = {1'b0, o_io_hex[3], 1'b0, o_io_hex[2],
                        1'b0, o_io_hex[1], 1'b0, o_io_hex[0]};
      R_HEXHI: rword = {1'b0, o_io_hex[7], 1'b0, o_io_hex[6],
                        1'b0, o_io_hex[5], 1'b0, o_io_hex[4]};
      R_LCD:   rword = o_io_lcd;
      R_SW:    rword = i_io_sw;
      default: rword = '0;
    endcase
  end

  assign bval = rword[{i_lsu_addr[1:0], 3'b000} +: 8];
  assign hval = rword[{i_lsu_addr[1], 4'b0000} +: 16];

  // Align the addressed byte/half to bit 0 and extend.
  always_comb begin
    o_ld_data = rword;
    case (i_lsu_size)
      2'b00:   o_ld_data = {{24{bval[7] & ~uns}}, bval};
      2'b01:   o_ld_data = {{16{hval[15] & ~uns}}, hval};
      default: o_ld_data = rword;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: load results are queued on a scoreboard when
// the load is issued and compared when o_ld_data settles.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, st_data, ld_data, ledr, ledg, lcd, sw;
  logic [1:0]  size;
  logic        wren;
  logic        lsu_unsigned;
  logic [6:0]  hex [0:7];

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [$];
  logic [31:0] got, exp;

  always #5 clk = ~clk;

  lsu dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_lsu_addr (addr),
    .i_st_data  (st_data),
    .i_lsu_size (size),
`ifdef LSU_UNSIGNED_EN
    .i_lsu_unsigned (lsu_unsigned),
`endif
    .i_lsu_wren (wren),
    .o_ld_data  (ld_data),
    .o_io_ledr  (ledr),
    .o_io_ledg  (ledg),
    .o_io_hex   (hex),
    .o_io_lcd   (lcd),
    .i_io_sw    (sw)
  );

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic we);
    addr = a; st_data = d; size = sz; wren = we;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    drive(a, d, sz, 1'b1);
    @(posedge clk);
    #1 wren = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, output logic [31:0] v);
    @(negedge clk);
    drive(a, 32'h0, sz, 1'b0);
    #1 v = ld_data;
  endtask

  task automatic test_reset();
    logic [31:0] hexcat;
    hexcat = '0;
    for (int n = 0; n < 8; n++) hexcat = hexcat | {25'h0, hex[n]};
    tests++; if (ledr !== 32'h0) begin fails++; $display("FAIL reset_ledr: got %h want 0", ledr); end
    tests++; if (ledg !== 32'h0) begin fails++; $display("FAIL reset_ledg: got %h want 0", ledg); end
    tests++; if (lcd  !== 32'h0) begin fails++; $display("FAIL reset_lcd: got %h want 0", lcd); end
    tests++; if (hexcat !== 32'h0) begin fails++; $display("FAIL reset_hex: got %h want 0", hexcat); end
  endtask

  task automatic test_word();
    store(32'h0, 32'h11223344, 2'b10);
    sb.push_back(32'h11223344);
    load(32'h0, 2'b10, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL lw_word: got %h want %h", got, exp); end
    // size 11 behaves as word
    store(32'hC, 32'hA1B2C3D4, 2'b11);
    sb.push_back(32'hA1B2C3D4);
    load(32'hC, 2'b11, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL size11_word: got %h want %h", got, exp); end
  endtask

  task automatic test_byte();
    store(32'h4, 32'h0, 2'b10);
    store(32'h5, 32'h123456AA, 2'b00);
    sb.push_back(32'h0000AA00);
    load(32'h4, 2'b10, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL sb_lane: got %h want %h", got, exp); end
    sb.push_back(32'hFFFFFFAA);
    load(32'h5, 2'b00, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL lb_sext: got %h want %h", got, exp); end
`ifdef LSU_UNSIGNED_EN
    lsu_unsigned = 1'b1;
    sb.push_back(32'h000000AA);
    load(32'h5, 2'b00, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL lbu_zext: got %h want %h", got, exp); end
    lsu_unsigned = 1'b0;
`endif
  endtask

  task automatic test_half();
    store(32'h2, 32'hFFFF8001, 2'b01);
    sb.push_back(32'h80013344);
    load(32'h0, 2'b10, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL sh_lane: got %h want %h", got, exp); end
    sb.push_back(32'hFFFF8001);
    load(32'h2, 2'b01, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL lh_sext: got %h want %h", got, exp); end
    sb.push_back(32'hFFFF8001);  // addr[0] ignored for halves
    load(32'h3, 2'b01, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL lh_odd: got %h want %h", got, exp); end
    sb.push_back(32'h00003344);
    load(32'h1, 2'b01, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL lh_low: got %h want %h", got, exp); end
  endtask

  task automatic test_switch();
    sw = 32'hDEADBEEF;
    sb.push_back(32'hDEADBEEF);
    load(32'h10010000, 2'b10, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL sw_read: got %h want %h", got, exp); end
    store(32'h10010000, 32'h0, 2'b10);
    sb.push_back(32'hDEADBEEF);
    load(32'h10010000, 2'b10, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL sw_ro: got %h want %h", got, exp); end
    sw = 32'h00000080;
    sb.push_back(32'hFFFFFF80);
    load(32'h10010000, 2'b00, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL sw_lb: got %h want %h", got, exp); end
  endtask

  task automatic test_periph();
    logic [6:0] hx [0:3];
    store(32'h10002000, 32'h3F065B4F, 2'b10);
    hx[0] = 7'h4F; hx[1] = 7'h5B; hx[2] = 7'h06; hx[3] = 7'h3F;
    for (int n = 0; n < 4; n++) begin
      tests++;
      if (hex[n] !== hx[n]) begin fails++; $display("FAIL hex%0d: got %h want %h", n, hex[n], hx[n]); end
    end
    store(32'h10003001, 32'h000000FF, 2'b00);
    tests++; if (hex[5] !== 7'h7F) begin fails++; $display("FAIL hex5: got %h want 7f", hex[5]); end
    sb.push_back(32'h00007F00);  // bit 7 of each lane reads 0
    load(32'h10003000, 2'b10, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL hex_bit7: got %h want %h", got, exp); end
    store(32'h10000000, 32'h5, 2'b10);
    tests++; if (ledr !== 32'h5) begin fails++; $display("FAIL ledr: got %h want 5", ledr); end
    store(32'h10004000, 32'hA5A5A5A5, 2'b10);
    store(32'h10004002, 32'h00001234, 2'b01);
    tests++; if (lcd !== 32'h1234A5A5) begin fails++; $display("FAIL lcd_half: got %h want 1234a5a5", lcd); end
    store(32'h10001003, 32'h000000C3, 2'b00);
    sb.push_back(32'hC3000000);
    load(32'h10001000, 2'b10, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL ledg_byte: got %h want %h", got, exp); end
    // reset takes priority over a concurrent store
    @(negedge clk);
    rst = 1'b1;
    drive(32'h10000000, 32'hFFFF, 2'b10, 1'b1);
    @(posedge clk);
    #1 wren = 1'b0; rst = 1'b0;
    test_reset();
  endtask

  task automatic test_unmapped();
    store(32'h20000000, 32'hFFFFFFFF, 2'b10);
    sb.push_back(32'h0);
    load(32'h20000000, 2'b10, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL unmapped_ld: got %h want %h", got, exp); end
    store(32'h00000800, 32'hFFFFFFFF, 2'b10);  // just past DMEM, must not alias 0x0
    sb.push_back(32'h80013344);
    load(32'h0, 2'b10, got); exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL dmem_alias: got %h want %h", got, exp); end
    tests++; if (ledr !== 32'h0) begin fails++; $display("FAIL unmapped_st: got %h want 0", ledr); end
  endtask

  task automatic test_back_to_back();
    store(32'h8, 32'h12345678, 2'b10);
    @(negedge clk);
    drive(32'h8, 32'hCAFEBABE, 2'b10, 1'b1);
    sb.push_back(32'h12345678);
    #1 got = ld_data; exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL same_cycle: got %h want %h", got, exp); end
    sb.push_back(32'hCAFEBABE);
    @(posedge clk);
    #1 wren = 1'b0;
    #1 got = ld_data; exp = sb.pop_front();
    tests++; if (got !== exp) begin fails++; $display("FAIL raw: got %h want %h", got, exp); end
  endtask

  // Random byte/half/word traffic against a byte-array model of 0x100..0x13F.
  task automatic test_random();
    logic [7:0]  mm [0:63];
    logic [31:0] d, a;
    logic [1:0]  sz;
    int          o, bs;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      store(32'h100 + 32'(4*w), d, 2'b10);
      for (int b = 0; b < 4; b++) mm[4*w+b] = d[8*b +: 8];
    end
    for (int i = 0; i < 80; i++) begin
      o  = $urandom_range(0, 63);
      a  = 32'h100 + 32'(o);
      sz = 2'($urandom_range(0, 3));
      d  = $urandom;
`ifdef LSU_UNSIGNED_EN
      lsu_unsigned = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 1) == 1) begin
        store(a, d, sz);
        if (sz == 2'b00) mm[o] = d[7:0];
        else if (sz == 2'b01) begin bs = o & ~1; mm[bs] = d[7:0]; mm[bs+1] = d[15:8]; end
        else begin bs = o & ~3; for (int b = 0; b < 4; b++) mm[bs+b] = d[8*b +: 8]; end
      end else begin
        if (sz == 2'b00)
          exp = (mm[o][7] && !lsu_unsigned) ? {24'hFFFFFF, mm[o]} : {24'h0, mm[o]};
        else if (sz == 2'b01) begin
          bs = o & ~1;
          exp = (mm[bs+1][7] && !lsu_unsigned) ? {16'hFFFF, mm[bs+1], mm[bs]}
                                               : {16'h0, mm[bs+1], mm[bs]};
        end else begin
          bs = o & ~3;
          exp = {mm[bs+3], mm[bs+2], mm[bs+1], mm[bs]};
        end
        sb.push_back(exp);
        load(a, sz, got); exp = sb.pop_front();
        tests++;
        if (got !== exp) begin
          fails++; $display("FAIL rand_ld a=%h sz=%0d: got %h want %h", a, sz, got, exp);
        end
      end
    end
    lsu_unsigned = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lsu_unsigned = 1'b0; sw = 32'h0;
    drive(32'h0, 32'h0, 2'b10, 1'b0);
    repeat (2) @(posedge clk);
    #1 test_reset();
    rst = 1'b0;
    test_word();
    test_byte();
    test_half();
    test_switch();
    test_periph();
    test_unmapped();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
